input_conditioner: RTL

Front-end conditioning for the board's raw pushbuttons and slide switches. It produces the debounced button and switch signals consumed by the LED driver blocks. Each channel has a two-flop synchroniser, a per-channel stability counter and a registered debounced level. Buttons additionally get a single-cycle press pulse, so one physical press advances a downstream driver exactly once.

---
 rtl/input_conditioner_if.sv | 22 ++
 rtl/input_conditioner.sv | 77 +++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Pin-side bundle of the input conditioner: raw button/switch pins in,
// debounced levels and press pulses out.
interface input_conditioner_if #(
    parameter int N_BTN = 3,
    parameter int N_SW  = 2
);
    logic [N_BTN-1:0] btn_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_SW-1:0]  sw_level;

    modport master (
        output btn_raw, sw_raw,
        input  btn_level, btn_pulse, sw_level
    );

    modport slave (
        input  btn_raw, sw_raw,
        output btn_level, btn_pulse, sw_level
    );
endinterface

// File: rtl/input_conditioner.sv
// Pushbutton/switch front end: 2-flop synchroniser, per-channel stability
// counter, registered debounced level and a single-cycle press pulse per button.
module input_conditioner #(
    parameter int N_BTN           = 3,
    parameter int N_SW            = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic               clk,
    input  logic               async_nreset,
    input_conditioner_if.slave io
);
    // Buttons occupy the low channel indices, switches the high ones.
    localparam int N_CH = N_BTN + N_SW;
    localparam logic [N_CH-1:0] INACTIVE_RAW =
        BTN_ACTIVE_LOW ? {{N_SW{1'b0}}, {N_BTN{1'b1}}} : {N_CH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};

    logic [N_CH-1:0]      s1_r;
    logic [N_CH-1:0]      s2_r;
    logic [N_CH-1:0]      level_r;
    logic [N_BTN-1:0]     pulse_r;
    logic [CNT_WIDTH-1:0] cnt_r       [N_CH];

    logic [N_CH-1:0]      norm_s;
    logic [N_CH-1:0]      level_nxt_s;
    logic [N_CH-1:0]      press_s;
    logic [CNT_WIDTH-1:0] cnt_nxt_s   [N_CH];

    assign norm_s = s2_r ^ INACTIVE_RAW;

    // Per-channel stability counting and level acceptance.
    always_comb begin
        level_nxt_s = level_r;
        press_s     = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            cnt_nxt_s[i] = cnt_r[i];
            if (norm_s[i] == level_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                level_nxt_s[i] = norm_s[i];
                cnt_nxt_s[i]   = CNT_ZERO;
                press_s[i]     = norm_s[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // State registers; reset parks the synchroniser on the released/off value.
    always_ff @(posedge clk) begin
        if (!async_nreset) begin
            s1_r    <= INACTIVE_RAW;
            s2_r    <= INACTIVE_RAW;
            level_r <= {N_CH{1'b0}};
            pulse_r <= {N_BTN{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            s1_r    <= {io.sw_raw, io.btn_raw};
            s2_r    <= s1_r;
            level_r <= level_nxt_s;
            pulse_r <= press_s[N_BTN-1:0];
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    assign io.btn_level = level_r[N_BTN-1:0];
    assign io.sw_level  = level_r[N_CH-1:N_BTN];
    assign io.btn_pulse = pulse_r;
endmodule
